// File: rtl/ym3438_pkg.sv
// Shared constants and types for the YM3438 CPU-side register slice.
// Channel entries are packed {L, R, AMS, PMS}.
package ym3438_pkg;

    localparam logic [7:0] ADDR_TEST  = 8'h21;
    localparam logic [7:0] ADDR_LFO   = 8'h22;
    localparam logic [7:0] ADDR_PANMS = 8'hB4;

    localparam int         CH_NUM  = 6;
    localparam logic [4:0] CYC_NUM = 5'd24;

    typedef struct packed {
        logic       l;
        logic       r;
        logic [1:0] ams;
        logic [2:0] pms;
    } ch_entry_t;

    localparam ch_entry_t ENTRY_RESET = 7'b11_00_000;

    // Slot cycles 0..23 visit channels 0..5 four times per frame.
    function automatic logic [2:0] ch_of_cyc(input logic [4:0] cyc);
        return 3'(cyc % 5'd6);
    endfunction

endpackage

// File: rtl/ym3438_busy_cnt.sv
// Write-busy down-counter: reloads on every data write, counts down on c1.
// A load in the same cycle as a c1 decrement wins.
module ym3438_busy_cnt #(
    parameter int LOAD = 32,
    parameter int W    = $clog2(LOAD + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic busy
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(LOAD);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Drops on the same edge as the c1 that brings the count to zero.
    assign busy = (cnt != '0);

endmodule

// File: rtl/ym3438_lfo_regs.sv
// Decodes address/data port writes into the test, LFO and pan/AMS/PMS registers
// and streams the current slot's channel modulation settings out on c1.
module ym3438_lfo_regs
    import ym3438_pkg::*;
#(
    parameter int BUSY_CYCLES = 32
) (
    input  logic       MCLK,
    input  logic       IC,
    input  logic       c1,
    input  logic       c2,
    input  logic       wr,
    input  logic       a0,
    input  logic       a1,
    input  logic [7:0] din,
    input  logic [4:0] fsm_cyc,
    output logic [7:0] reg_21,
    output logic [3:0] lfo,
    output logic [2:0] pms,
    output logic [1:0] ams,
    output logic       pan_l,
    output logic       pan_r,
    output logic       busy
);

    logic       addr_w;
    logic       data_w;
    logic       slot_en;
    logic [8:0] addr_q;
    logic       wr_hit;
    logic [2:0] wr_ch;
    logic [7:0] addr_off;
    ch_entry_t  ch_mem [CH_NUM];
    ch_entry_t  rd_entry;

    assign addr_w   = wr & ~a0;
    assign data_w   = wr & a0;
    // c1 and c2 never overlap; masking c2 keeps the read strictly on phase 1.
    assign slot_en  = c1 & ~c2;
    assign addr_off = addr_q[7:0] - ADDR_PANMS;

    always_comb begin
        wr_hit = 1'b0;
        wr_ch  = '0;
        if (data_w && addr_q[7:0] >= ADDR_PANMS && addr_q[7:0] <= ADDR_PANMS + 8'd2) begin
            wr_hit = 1'b1;
            wr_ch  = 3'(addr_off) + (addr_q[8] ? 3'd3 : 3'd0);
        end
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            addr_q <= '0;
            reg_21 <= '0;
            lfo    <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                ch_mem[i] <= ENTRY_RESET;
            end
        end else begin
            if (addr_w) begin
                addr_q <= {a1, din};
            end
            // Test and LFO registers exist only in bank 0.
            if (data_w && addr_q == {1'b0, ADDR_TEST}) begin
                reg_21 <= din;
            end
            if (data_w && addr_q == {1'b0, ADDR_LFO}) begin
                lfo <= din[3:0];
            end
            if (wr_hit) begin
                ch_mem[wr_ch] <= '{l: din[7], r: din[6], ams: din[5:4], pms: din[2:0]};
            end
        end
    end

    assign rd_entry = ch_mem[ch_of_cyc(fsm_cyc)];

    // Illegal slot cycles 24..31 leave the previous channel's values in place.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            pan_l <= ENTRY_RESET.l;
            pan_r <= ENTRY_RESET.r;
            ams   <= ENTRY_RESET.ams;
            pms   <= ENTRY_RESET.pms;
        end else if (slot_en && fsm_cyc < CYC_NUM) begin
            pan_l <= rd_entry.l;
            pan_r <= rd_entry.r;
            ams   <= rd_entry.ams;
            pms   <= rd_entry.pms;
        end
    end

    ym3438_busy_cnt #(
        .LOAD (BUSY_CYCLES)
    ) u_busy_cnt (
        .clk   (MCLK),
        .rst_n (IC),
        .load  (data_w),
        .en    (slot_en),
        .busy  (busy)
    );

endmodule

// File: tb/tb_ym3438_lfo_regs.sv
// Directed bench for ym3438_lfo_regs: table of register writes with hand-computed
// results, plus sequences for busy timing, slot-read collisions and reset.
module tb_ym3438_lfo_regs;

    logic       MCLK = 1'b0;
    logic       IC;
    logic       c1;
    logic       c2;
    logic       wr;
    logic       a0;
    logic       a1;
    logic [7:0] din;
    logic [4:0] fsm_cyc;
    logic [7:0] reg_21;
    logic [3:0] lfo;
    logic [2:0] pms;
    logic [1:0] ams;
    logic       pan_l;
    logic       pan_r;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [6:0] exp_ch [6];
    logic [6:0] reset_entry;

    typedef struct {
        logic       a1;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_reg21;
        logic [3:0] exp_lfo;
        int         ch;
        logic [6:0] exp_entry;
    } vec_t;

    vec_t vecs [10];

    ym3438_lfo_regs #(.BUSY_CYCLES(32)) dut (
        .MCLK    (MCLK),
        .IC      (IC),
        .c1      (c1),
        .c2      (c2),
        .wr      (wr),
        .a0      (a0),
        .a1      (a1),
        .din     (din),
        .fsm_cyc (fsm_cyc),
        .reg_21  (reg_21),
        .lfo     (lfo),
        .pms     (pms),
        .ams     (ams),
        .pan_l   (pan_l),
        .pan_r   (pan_r),
        .busy    (busy)
    );

    // Clock / reset
    always #5 MCLK = ~MCLK;

    task automatic mclk();
        @(posedge MCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic write_addr(input logic bank, input logic [7:0] addr);
        a0 = 1'b0; a1 = bank; din = addr; wr = 1'b1;
        mclk();
        wr = 1'b0;
    endtask

    task automatic write_data(input logic [7:0] data);
        a0 = 1'b1; a1 = 1'b0; din = data; wr = 1'b1;
        mclk();
        wr = 1'b0;
    endtask

    task automatic c1_step(input logic [4:0] cyc);
        fsm_cyc = cyc; c1 = 1'b1;
        mclk();
        c1 = 1'b0;
    endtask

    task automatic phase_tail();
        mclk();
        c2 = 1'b1;
        mclk();
        c2 = 1'b0;
        mclk();
    endtask

    task automatic scan_channels(input string tag);
        for (int c = 0; c < 24; c++) begin
            c1_step(5'(c));
            check(tag, {pan_l, pan_r, ams, pms}, exp_ch[c % 6]);
            phase_tail();
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            c1_step(5'd0);
            n++;
            phase_tail();
        end
    endtask

    initial begin
        int n;
        reset_entry = 7'b11_00_000;
        vecs[0] = '{1'b0, 8'h22, 8'h0B, 8'h00, 4'hB, -1, 7'h00};
        vecs[1] = '{1'b1, 8'hB5, 8'h76, 8'h00, 4'hB,  4, 7'b0_1_11_110};
        vecs[2] = '{1'b1, 8'h22, 8'hFF, 8'h00, 4'hB, -1, 7'h00};
        vecs[3] = '{1'b0, 8'hB7, 8'h00, 8'h00, 4'hB, -1, 7'h00};
        vecs[4] = '{1'b0, 8'h21, 8'h5A, 8'h5A, 4'hB, -1, 7'h00};
        vecs[5] = '{1'b1, 8'h21, 8'h33, 8'h5A, 4'hB, -1, 7'h00};
        vecs[6] = '{1'b0, 8'hB4, 8'hC5, 8'h5A, 4'hB,  0, 7'b1_1_00_101};
        vecs[7] = '{1'b1, 8'hB6, 8'h9A, 8'h5A, 4'hB,  5, 7'b1_0_01_010};
        vecs[8] = '{1'b0, 8'h22, 8'hF3, 8'h5A, 4'h3, -1, 7'h00};
        vecs[9] = '{1'b0, 8'hB6, 8'h4F, 8'h5A, 4'h3,  2, 7'b0_1_00_111};
        for (int i = 0; i < 6; i++) exp_ch[i] = reset_entry;

        IC = 1'b0; c1 = 1'b0; c2 = 1'b0; wr = 1'b0; a0 = 1'b0; a1 = 1'b0;
        din = '0; fsm_cyc = '0;
        repeat (3) mclk();
        IC = 1'b1;
        mclk();

        check("rst_reg21", reg_21, 8'h00);
        check("rst_lfo", lfo, 4'h0);
        check("rst_busy", busy, 1'b0);
        scan_channels("rst_ch");
        check("rst_busy_after_scan", busy, 1'b0);

        // Busy lasts exactly 32 c1 phases
        write_addr(1'b0, 8'h22);
        write_data(8'h0B);
        check("lfo_0b", lfo, 4'hB);
        check("busy_set", busy, 1'b1);
        count_busy(n);
        check("busy_len", n, 32);

        // Table-driven register writes
        for (int v = 0; v < 10; v++) begin
            write_addr(vecs[v].a1, vecs[v].addr);
            write_data(vecs[v].data);
            check("vec_reg21", reg_21, vecs[v].exp_reg21);
            check("vec_lfo", lfo, vecs[v].exp_lfo);
            check("vec_busy", busy, 1'b1);
            if (vecs[v].ch >= 0) exp_ch[vecs[v].ch] = vecs[v].exp_entry;
            scan_channels("vec_ch");
        end

        // Address latch persists across data writes
        write_addr(1'b0, 8'h21);
        write_data(8'h11);
        check("latch_reg21_a", reg_21, 8'h11);
        write_data(8'h22);
        check("latch_reg21_b", reg_21, 8'h22);

        // Reload part-way: busy runs 32 more c1 phases from count 5
        write_data(8'h22);
        for (int i = 0; i < 27; i++) begin
            c1_step(5'd0);
            phase_tail();
        end
        check("busy_at_5", busy, 1'b1);
        write_data(8'h22);
        count_busy(n);
        check("busy_reload_len", n, 32);

        // Write coincident with the c1 that would reach zero: reload wins
        write_data(8'h22);
        for (int i = 0; i < 31; i++) begin
            c1_step(5'd0);
            phase_tail();
        end
        fsm_cyc = 5'd0; c1 = 1'b1; a0 = 1'b1; din = 8'h22; wr = 1'b1;
        mclk();
        c1 = 1'b0; wr = 1'b0;
        check("busy_wr_on_zero", busy, 1'b1);
        phase_tail();
        count_busy(n);
        check("busy_wr_on_zero_len", n, 32);

        // Illegal slot cycles hold the previous output
        c1_step(5'd4);
        check("illegal_pre", {pan_l, pan_r, ams, pms}, exp_ch[4]);
        phase_tail();
        c1_step(5'd27);
        check("illegal_27", {pan_l, pan_r, ams, pms}, exp_ch[4]);
        phase_tail();
        c1_step(5'd31);
        check("illegal_31", {pan_l, pan_r, ams, pms}, exp_ch[4]);
        phase_tail();
        c1_step(5'd7);
        check("illegal_recover", {pan_l, pan_r, ams, pms}, exp_ch[1]);
        phase_tail();

        // Same-cycle write and read of channel 0: old value first, new on next visit
        write_addr(1'b0, 8'hB4);
        fsm_cyc = 5'd0; c1 = 1'b1; a0 = 1'b1; din = 8'h80; wr = 1'b1;
        mclk();
        c1 = 1'b0; wr = 1'b0;
        check("collide_old", {pan_l, pan_r, ams, pms}, exp_ch[0]);
        phase_tail();
        exp_ch[0] = 7'b1_0_00_000;
        c1_step(5'd6);
        check("collide_new", {pan_l, pan_r, ams, pms}, exp_ch[0]);
        phase_tail();

        // Asynchronous reset mid-busy
        write_addr(1'b0, 8'hB4);
        write_data(8'h37);
        check("pre_rst_busy", busy, 1'b1);
        #2;
        IC = 1'b0;
        #1;
        check("arst_reg21", reg_21, 8'h00);
        check("arst_lfo", lfo, 4'h0);
        check("arst_busy", busy, 1'b0);
        check("arst_ch", {pan_l, pan_r, ams, pms}, reset_entry);
        mclk();
        IC = 1'b1;
        mclk();
        for (int i = 0; i < 6; i++) exp_ch[i] = reset_entry;
        // Latch cleared: a bare data write targets 0x000 and changes nothing
        write_data(8'h55);
        check("post_rst_reg21", reg_21, 8'h00);
        check("post_rst_lfo", lfo, 4'h0);
        check("post_rst_busy", busy, 1'b1);
        scan_channels("post_rst_ch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
